// File: rtl/pipelined_lookahead_adder_if.sv
// rtl/pipelined_lookahead_adder_if.sv - operand/result handshake bundle for the pipelined lookahead adder
interface pipelined_lookahead_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/pipelined_lookahead_adder.sv
// rtl/pipelined_lookahead_adder.sv - pipelined carry-lookahead adder/subtractor, one stage per GROUP-bit slice
module pipelined_lookahead_adder #(
    parameter int WIDTH = 8,
    parameter int GROUP = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_lookahead_adder_if.slave bus
);
    localparam int STAGES = WIDTH / GROUP;

    logic              advance;
    logic [WIDTH-1:0]  b_eff;
    logic              cin0;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic              last_cin;
    logic [WIDTH-1:0]  sum_w;

    // Whole pipeline moves as one; a stall freezes every register.
    assign advance      = !valid_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign cin0         = bus.sub | bus.ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUP-1:0] a_k;
        logic [GROUP-1:0] b_k;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   cc;
        logic             cin_k;
        logic             vin_k;
        logic             v_q;
        logic             c_q;
        logic [GROUP-1:0] sum_q;

        if (k == 0) begin : g_head
            assign a_k   = bus.a[GROUP-1:0];
            assign b_k   = b_eff[GROUP-1:0];
            assign cin_k = cin0;
            assign vin_k = bus.in_valid;
        end else begin : g_skew
            // Operand slice k waits k cycles so it meets its carry from stage k-1.
            logic [GROUP-1:0] a_sk [k];
            logic [GROUP-1:0] b_sk [k];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        a_sk[i] <= '0;
                        b_sk[i] <= '0;
                    end
                end else if (advance) begin
                    a_sk[0] <= bus.a[k*GROUP +: GROUP];
                    b_sk[0] <= b_eff[k*GROUP +: GROUP];
                    for (int i = 1; i < k; i++) begin
                        a_sk[i] <= a_sk[i-1];
                        b_sk[i] <= b_sk[i-1];
                    end
                end
            end
            assign a_k   = a_sk[k-1];
            assign b_k   = b_sk[k-1];
            assign cin_k = carry_q[k-1];
            assign vin_k = valid_q[k-1];
        end

        assign g = a_k & b_k;
        assign p = a_k ^ b_k;

        // Each carry is a flat sum of generate/propagate products, no ripple.
        always_comb begin
            logic term;
            term = 1'b0;
            cc   = '0;
            for (int i = 0; i <= GROUP; i++) begin
                term = cin_k;
                for (int j = 0; j < i; j++) term = term & p[j];
                cc[i] = term;
                for (int j = 0; j < i; j++) begin
                    term = g[j];
                    for (int m = j + 1; m < i; m++) term = term & p[m];
                    cc[i] = cc[i] | term;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= vin_k;
                c_q   <= cc[GROUP];
                sum_q <= p ^ cc[GROUP-1:0];
            end
        end

        assign valid_q[k] = v_q;
        assign carry_q[k] = c_q;

        if (k == STAGES - 1) begin : g_tail
            logic msb_cin_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    msb_cin_q <= 1'b0;
                end else if (advance) begin
                    msb_cin_q <= cc[GROUP-1];
                end
            end
            assign last_cin                  = msb_cin_q;
            assign sum_w[k*GROUP +: GROUP]   = sum_q;
        end else begin : g_deskew
            // Early slices wait for the final slice so the sum leaves as one word.
            localparam int DEPTH = STAGES - 1 - k;
            logic [GROUP-1:0] d_q [DEPTH];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
                end else if (advance) begin
                    d_q[0] <= sum_q;
                    for (int i = 1; i < DEPTH; i++) d_q[i] <= d_q[i-1];
                end
            end
            assign sum_w[k*GROUP +: GROUP] = d_q[DEPTH-1];
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_w;
    assign bus.co        = carry_q[STAGES-1];
    assign bus.ovf       = carry_q[STAGES-1] ^ last_cin;
endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// tb/tb_pipelined_lookahead_adder.sv - randomized self-checking bench for pipelined_lookahead_adder
module tb_pipelined_lookahead_adder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_lookahead_adder_if #(.WIDTH(8))  m_if ();
    pipelined_lookahead_adder_if #(.WIDTH(2))  s22_if ();
    pipelined_lookahead_adder_if #(.WIDTH(2))  s21_if ();
    pipelined_lookahead_adder_if #(.WIDTH(16)) s16_if ();

    pipelined_lookahead_adder #(.WIDTH(8),  .GROUP(2)) u_main (.clk(clk), .rst(rst), .bus(m_if));
    pipelined_lookahead_adder #(.WIDTH(2),  .GROUP(2)) u_s22  (.clk(clk), .rst(rst), .bus(s22_if));
    pipelined_lookahead_adder #(.WIDTH(2),  .GROUP(1)) u_s21  (.clk(clk), .rst(rst), .bus(s21_if));
    pipelined_lookahead_adder #(.WIDTH(16), .GROUP(4)) u_s16  (.clk(clk), .rst(rst), .bus(s16_if));

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        int          t;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } vec_t;

    res_t exp_q[$];
    res_t got_q[$];
    logic obs_in_ready;
    logic obs_out_valid;
    logic [9:0] obs_word;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t ref_model(logic [7:0] a, logic [7:0] b, logic ci, logic sub, int t);
        res_t x;
        int   r;
        int   sr;
        if (sub) begin
            r    = int'(a) - int'(b);
            sr   = int'($signed(a)) - int'($signed(b));
            x.co = (int'(a) >= int'(b));
        end else begin
            r    = int'(a) + int'(b) + int'(ci);
            sr   = int'($signed(a)) + int'($signed(b)) + int'(ci);
            x.co = (r > 255);
        end
        x.sum = 16'(r & 255);
        x.ovf = (sr > 127) || (sr < -128);
        x.t   = t;
        return x;
    endfunction

    task automatic tick(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub, input logic ordy);
        m_if.in_valid  = v;
        m_if.a         = a;
        m_if.b         = b;
        m_if.ci        = ci;
        m_if.sub       = sub;
        m_if.out_ready = ordy;
        #1;
        obs_in_ready  = m_if.in_ready;
        obs_out_valid = m_if.out_valid;
        obs_word      = {m_if.co, m_if.ovf, m_if.sum};
        if (m_if.out_valid && m_if.out_ready)
            got_q.push_back('{16'(m_if.sum), m_if.co, m_if.ovf, cyc});
        if (v && m_if.in_ready)
            exp_q.push_back(ref_model(a, b, ci, sub, cyc));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0; m_if.ci = 1'b0; m_if.sub = 1'b0; m_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.sum !== 8'h00 || m_if.co !== 1'b0 || m_if.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b sum=%h co=%b ovf=%b want 0/00/0/0",
                     m_if.out_valid, m_if.sum, m_if.co, m_if.ovf);
        end
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b want 1", m_if.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        vec_t tbl [9];
        tbl = '{'{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
                '{8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0},
                '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
                '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
                '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0},
                '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
                '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
                '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
                '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1}};
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) tick(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, 1'b1);
        drain(8);
        checks++;
        if (got_q.size() != 9) begin
            failures++;
            $display("FAIL directed_count got %0d want 9", got_q.size());
        end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].sum[7:0] !== tbl[i].s || got_q[i].co !== tbl[i].co || got_q[i].ovf !== tbl[i].ovf) begin
                failures++;
                $display("FAIL directed[%0d] got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                         i, got_q[i].sum[7:0], got_q[i].co, got_q[i].ovf, tbl[i].s, tbl[i].co, tbl[i].ovf);
            end
            checks++;
            if (got_q[i].t - exp_q[i].t != 4) begin
                failures++;
                $display("FAIL directed_latency[%0d] got %0d want 4", i, got_q[i].t - exp_q[i].t);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ra [10];
        logic [7:0] rb [10];
        logic       rc [10];
        logic       rs [10];
        logic [9:0] held;
        logic       ordy;
        int         idx;
        int         t;
        for (int i = 0; i < 10; i++) begin
            ra[i] = 8'($urandom); rb[i] = 8'($urandom);
            rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        got_q.delete(); exp_q.delete();
        held = '0; idx = 0; t = 0;
        while (idx < 10 && t < 100) begin
            ordy = !(t >= 6 && t <= 8);
            tick(1'b1, ra[idx], rb[idx], rc[idx], rs[idx], ordy);
            if (obs_out_valid && !ordy) begin
                checks++;
                if (obs_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL backpressure_in_ready t=%0d got %b want 0", t, obs_in_ready);
                end
            end
            if (t == 6) held = obs_word;
            if (t == 7 || t == 8) begin
                checks++;
                if (obs_word !== held) begin
                    failures++;
                    $display("FAIL stall_hold t=%0d got %h want %h", t, obs_word, held);
                end
            end
            if (obs_in_ready) idx++;
            t++;
        end
        drain(10);
        checks++;
        if (idx != 10 || got_q.size() != 10) begin
            failures++;
            $display("FAIL stream_count got sent=%0d recv=%0d want 10/10", idx, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].sum !== exp_q[i].sum || got_q[i].co !== exp_q[i].co || got_q[i].ovf !== exp_q[i].ovf) begin
                failures++;
                $display("FAIL stream[%0d] got %h/%b/%b want %h/%b/%b", i, got_q[i].sum, got_q[i].co,
                         got_q[i].ovf, exp_q[i].sum, exp_q[i].co, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_bubbles;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++)
            tick((i % 2) == 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        drain(8);
        checks++;
        if (got_q.size() != 6) begin
            failures++;
            $display("FAIL bubble_count got %0d want 6", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].sum !== exp_q[i].sum || got_q[i].co !== exp_q[i].co || got_q[i].t - exp_q[i].t != 4) begin
                failures++;
                $display("FAIL bubble[%0d] got %h/%b lat=%0d want %h/%b lat=4", i, got_q[i].sum, got_q[i].co,
                         got_q[i].t - exp_q[i].t, exp_q[i].sum, exp_q[i].co);
            end
        end
    endtask

    task automatic test_random;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 400; i++)
            tick(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0);
        drain(10);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].sum !== exp_q[i].sum || got_q[i].co !== exp_q[i].co || got_q[i].ovf !== exp_q[i].ovf) begin
                failures++;
                $display("FAIL random[%0d] got %h/%b/%b want %h/%b/%b", i, got_q[i].sum, got_q[i].co,
                         got_q[i].ovf, exp_q[i].sum, exp_q[i].co, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_reset_mid;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
        checks++;
        if (m_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid got %b want 1", m_if.out_valid);
        end
        m_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.sum !== 8'h00 || m_if.co !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear got valid=%b sum=%h co=%b want 0/00/0", m_if.out_valid, m_if.sum, m_if.co);
        end
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete(); exp_q.delete();
        drain(10);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL stale_after_reset got %0d results want 0", got_q.size());
        end
        tick(1'b1, 8'h3C, 8'h0F, 1'b1, 1'b0, 1'b1);
        drain(6);
        checks++;
        if (got_q.size() != 1 || got_q[0].sum !== 16'h004C || got_q[0].t - exp_q[0].t != 4) begin
            failures++;
            $display("FAIL post_reset_op got n=%0d sum=%h want n=1 sum=004c lat=4",
                     got_q.size(), got_q.size() > 0 ? got_q[0].sum : 16'hxxxx);
        end
    endtask

    task automatic test_sweep;
        res_t q22[$];
        res_t q21[$];
        res_t q16[$];
        res_t e;
        int   r;
        logic [15:0] a16;
        logic [15:0] b16;
        for (int i = 0; i < 1012; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            s22_if.in_valid = (i < 1000); s22_if.a = i[1:0]; s22_if.b = i[3:2]; s22_if.ci = i[4];
            s21_if.in_valid = (i < 1000); s21_if.a = i[1:0]; s21_if.b = i[3:2]; s21_if.ci = i[4];
            s16_if.in_valid = (i < 1000) && ($urandom_range(0, 3) != 0);
            s16_if.a = a16; s16_if.b = b16; s16_if.ci = 1'($urandom);
            #1;
            if (s22_if.out_valid) begin
                checks++;
                e = (q22.size() > 0) ? q22.pop_front() : '{16'hFFFF, 1'bx, 1'b0, -100};
                if (s22_if.sum !== e.sum[1:0] || s22_if.co !== e.co || cyc - e.t != 1) begin
                    failures++;
                    $display("FAIL sweep_w2g2 got %h/%b lat=%0d want %h/%b lat=1", s22_if.sum, s22_if.co, cyc - e.t, e.sum[1:0], e.co);
                end
            end
            if (s21_if.out_valid) begin
                checks++;
                e = (q21.size() > 0) ? q21.pop_front() : '{16'hFFFF, 1'bx, 1'b0, -100};
                if (s21_if.sum !== e.sum[1:0] || s21_if.co !== e.co || cyc - e.t != 2) begin
                    failures++;
                    $display("FAIL sweep_w2g1 got %h/%b lat=%0d want %h/%b lat=2", s21_if.sum, s21_if.co, cyc - e.t, e.sum[1:0], e.co);
                end
            end
            if (s16_if.out_valid) begin
                checks++;
                e = (q16.size() > 0) ? q16.pop_front() : '{16'hFFFF, 1'bx, 1'b0, -100};
                if (s16_if.sum !== e.sum || s16_if.co !== e.co || cyc - e.t != 4) begin
                    failures++;
                    $display("FAIL sweep_w16g4 got %h/%b lat=%0d want %h/%b lat=4", s16_if.sum, s16_if.co, cyc - e.t, e.sum, e.co);
                end
            end
            if (s22_if.in_valid && s22_if.in_ready) begin
                r = int'(s22_if.a) + int'(s22_if.b) + int'(s22_if.ci);
                q22.push_back('{16'(r % 4), r >= 4, 1'b0, cyc});
            end
            if (s21_if.in_valid && s21_if.in_ready) begin
                r = int'(s21_if.a) + int'(s21_if.b) + int'(s21_if.ci);
                q21.push_back('{16'(r % 4), r >= 4, 1'b0, cyc});
            end
            if (s16_if.in_valid && s16_if.in_ready) begin
                r = int'(a16) + int'(b16) + int'(s16_if.ci);
                q16.push_back('{16'(r % 65536), r >= 65536, 1'b0, cyc});
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (q22.size() != 0 || q21.size() != 0 || q16.size() != 0) begin
            failures++;
            $display("FAIL sweep_leftover got %0d/%0d/%0d want 0/0/0", q22.size(), q21.size(), q16.size());
        end
    endtask

    initial begin
        s22_if.in_valid = 1'b0; s22_if.a = '0; s22_if.b = '0; s22_if.ci = 1'b0; s22_if.sub = 1'b0; s22_if.out_ready = 1'b1;
        s21_if.in_valid = 1'b0; s21_if.a = '0; s21_if.b = '0; s21_if.ci = 1'b0; s21_if.sub = 1'b0; s21_if.out_ready = 1'b1;
        s16_if.in_valid = 1'b0; s16_if.a = '0; s16_if.b = '0; s16_if.ci = 1'b0; s16_if.sub = 1'b0; s16_if.out_ready = 1'b1;
        test_reset;
        test_directed;
        test_back_to_back;
        test_bubbles;
        test_random;
        test_reset_mid;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
